store_merge_unit: RTL
=====================

// Module: store_merge_unit
// PURPOSE
//   Store-side counterpart of the register-file load extractor. It writes SW/SH/SB data into a
//   word-wide data memory that has no byte enables.
//   - SW: a single write of the full word.
//   - SH/SB: read-modify-write. Read the aligned word, merge the rt lane(s), write the word back.
//   Sits between the EX/MEM stage and data memory. Drives busy to stall the pipeline until done.
// PARAMETERS
//   DATA_BITS   32   data/word width; only 32 supported (4 byte lanes)
//   ADDR_BITS   32   byte address width
// PORTS
//   clk         in   1          rising-edge clock
//   rst         in   1          asynchronous, active-high reset
//   start       in   1          store request; sampled only in IDLE
//   StoreWord   in   2          0 word, 1 byte, 2 halfword, 3 undefined (no-op)
//   addr        in   ADDR_BITS  byte address of store (alu_out)
//   wdata       in   DATA_BITS  register rt value; byte/half taken from low bits
//   mem_addr    out  ADDR_BITS  word-aligned address {addr[ADDR_BITS-1:2],2'b00}
//   mem_rd_en   out  1          read request, held until mem_ack
//   mem_rdata   in   DATA_BITS  read data, valid on the cycle mem_ack=1 in RD
//   mem_wr_en   out  1          write request, held until mem_ack
//   mem_wdata   out  DATA_BITS  merged word to write
//   mem_ack     in   1          memory handshake; ignored in IDLE/DONE
//   busy        out  1          high in RD, WR, DONE
//   done        out  1          one-cycle pulse in DONE
//   misalign    out  1          one-cycle pulse with done; alignment fault, memory untouched
// BEHAVIOUR
//   Reset:
//     - state=IDLE; mem_addr, mem_wdata, latched regs = 0; all strobes/busy/done/misalign = 0.
//     - Asynchronous assertion mid-operation drops mem_rd_en/mem_wr_en immediately and abandons the store.
//   FSM states: IDLE, RD, WR, DONE.
//     - IDLE & start: latch addr, wdata, StoreWord.
//     - IDLE & start, word aligned (addr[1:0]==0) -> WR, with mem_wdata = wdata.
//     - IDLE & start, byte, or half with addr[0]==0 -> RD.
//     - IDLE & start, misaligned (word with addr[1:0]!=0, or half with addr[0]==1) -> DONE, misalign=1.
//     - IDLE & start, StoreWord==3 -> DONE, misalign=0, no memory access.
//     - RD: mem_rd_en=1. On mem_ack, register the merged word into mem_wdata -> WR.
//     - WR: mem_wr_en=1, mem_wdata stable. On mem_ack -> DONE.
//     - DONE: done=1 (and misalign if faulted) for exactly one cycle -> IDLE.
//   Merge (byte): lane k=addr[1:0]; bits [8k+7:8k] = wdata[7:0]; other bits = mem_rdata.
//   Merge (half): addr[1]=0 -> [15:0]=wdata[15:0]; addr[1]=1 -> [31:16]=wdata[15:0];
//     other half = mem_rdata.
//   Strobes:
//     - mem_rd_en and mem_wr_en are never high together.
//     - mem_addr is held constant from the cycle after start until DONE.
//   Latency with mem_ack held high:
//     - word: start@edge0, WR cycle1, DONE cycle2, IDLE cycle3.
//     - byte/half: RD cycle1, WR cycle2, DONE cycle3.
//     - Each cycle without mem_ack extends RD/WR by one cycle.
//   start outside IDLE is ignored; no queuing. start in DONE is also ignored (caller waits for !busy).
//   Back-to-back: a new start in the IDLE cycle after DONE is accepted.
//   Address/data changes after start have no effect on an in-flight store.
// TESTING
//   1. SW addr=0x100 wdata=0xDEADBEEF, ack=1 -> one write, mem_addr=0x100,
//      mem_wdata=0xDEADBEEF, no read, done on cycle 2.
//   2. SB addr=0x103 wdata=0x000000AA, rdata=0x11223344 -> read 0x100, write 0xAA223344,
//      done on cycle 3.
//   3. SH addr=0x102 wdata=0xFFFF5678, rdata=0x11223344 -> write 0x56783344;
//      with addr=0x100 -> 0x11225678.
//   4. SH addr=0x101 or SW addr=0x102 -> done+misalign pulse on cycle 1, no rd/wr strobe.
//   5. SB with mem_ack low 3 cycles in RD and 2 in WR -> strobes held and mem_addr stable;
//      done on cycle 8; a second start during busy is ignored.
//   6. Assert rst during WR -> mem_wr_en drops the same cycle; after release: IDLE, busy=0, no done.

Source files
------------

// File: rtl/store_merge_unit.sv
// Store path to a word-wide data memory without byte enables: SW writes the word directly,
// while SB/SH read the aligned word, merge the rt lane(s) and write the word back.
module store_merge_unit #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           StoreWord,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd_en,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 mem_wr_en,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    output logic                 busy,
    output logic                 done,
    output logic                 misalign
);
    // state | meaning
    // IDLE  | waiting for start
    // RD    | reading the aligned word for a byte/half merge
    // WR    | writing the (merged) word
    // DONE  | one-cycle completion pulse, misalign flags a fault
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    state_t               state;
    logic [1:0]           size_q;
    logic [1:0]           lane_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [DATA_BITS-1:0] merged;

    always_comb begin
        merged = mem_rdata;
        case (size_q)
            SZ_BYTE: begin
                case (lane_q)
                    2'd0: merged[7:0]   = wdata_q[7:0];
                    2'd1: merged[15:8]  = wdata_q[7:0];
                    2'd2: merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane_q[1])
                    merged[31:16] = wdata_q[15:0];
                else
                    merged[15:0] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            size_q    <= '0;
            lane_q    <= '0;
            wdata_q   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= {addr[ADDR_BITS-1:2], 2'b00};
                        lane_q   <= addr[1:0];
                        size_q   <= StoreWord;
                        wdata_q  <= wdata;
                        busy     <= 1'b1;
                        case (StoreWord)
                            SZ_WORD: begin
                                if (addr[1:0] == 2'b00) begin
                                    state     <= WR;
                                    mem_wr_en <= 1'b1;
                                    mem_wdata <= wdata;
                                end else begin
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    misalign <= 1'b1;
                                end
                            end
                            SZ_BYTE: begin
                                state     <= RD;
                                mem_rd_en <= 1'b1;
                            end
                            SZ_HALF: begin
                                if (!addr[0]) begin
                                    state     <= RD;
                                    mem_rd_en <= 1'b1;
                                end else begin
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    misalign <= 1'b1;
                                end
                            end
                            default: begin
                                // undefined size: complete without touching memory
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        mem_wdata <= merged;
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b1;
                        state     <= WR;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        mem_wr_en <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
